result_scan_bcd: RTL and testbench
==================================

RESULT_SCAN_BCD -- requirements
Module: result_scan_bcd

Interface
REQ-001 Parameter TICK_CYCLES, default 25_000_000: clk cycles between element advances; SHALL be >= 16.
REQ-002 Parameter SAT_MAX, default 999: display saturation limit; SHALL be <= 999.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 done  input  1  matrix-core completion level.
REQ-006 result  input  4 x 128 unpacked array  result matrix; result[r] = row r, element c = bits [32c+31:32c], unsigned.
REQ-007 bcd_hundreds, bcd_tens, bcd_ones  output  4 each  BCD digits of the displayed element.
REQ-008 row_idx, col_idx  output  2 each  matrix coordinates of the displayed element.
REQ-009 bcd_valid  output  1  digits and coordinates are valid.
REQ-010 busy  output  1  high while a conversion is in progress (LOAD or SHIFT).

Function
REQ-011 done SHALL be registered once; capture event = done & ~done_q; a held-high done SHALL NOT re-trigger.
REQ-012 On a capture event, all 512 bits of result SHALL be copied into an internal snapshot; the scan uses only the snapshot.
REQ-013 Element index idx (0..15): row = 3 - idx[3:2], col = idx[1:0]; idx SHALL wrap 15 -> 0.
REQ-014 Tick counter SHALL count 0..TICK_CYCLES-1 only once a capture has occurred; tick = 1-cycle pulse at TICK_CYCLES-1, then the counter wraps to 0.
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT, HOLD.
- IDLE -> LOAD on capture.
- LOAD (1 cycle): select snapshot element; saturate (value > SAT_MAX ? SAT_MAX : value[11:0]); clear BCD accumulator.
- SHIFT (exactly 12 cycles): double-dabble; add 3 to each digit >= 5, then shift 1 bit.
- HOLD: wait for tick.
REQ-016 On entry to HOLD, digits, row_idx and col_idx SHALL update in the same cycle, and bcd_valid SHALL be 1 from then on.
REQ-017 Latency: capture or tick to updated outputs SHALL be exactly 14 cycles.
REQ-018 Outputs SHALL hold their previous values during LOAD and SHIFT.
REQ-019 A tick in HOLD SHALL increment idx (with wrap) and go to LOAD.
REQ-020 A tick outside HOLD SHALL set a 1-bit pending flag, consumed on HOLD entry as an immediate advance; further ticks while pending SHALL be dropped.
REQ-021 A capture in any state SHALL have priority. It reloads the snapshot, sets idx = 0, clears the tick counter and pending flag, aborts any conversion and goes to LOAD. bcd_valid keeps its value.
REQ-022 Saturation SHALL compare all 32 bits, so values >= 2^12 saturate and are not truncated.
REQ-023 busy = (state == LOAD or state == SHIFT).

Reset
REQ-024 While reset_n = 0, the following SHALL all be 0 and the FSM SHALL be in IDLE:
- all outputs;
- snapshot, idx, tick counter, pending flag, done_q.
REQ-025 Reset asserted mid-conversion SHALL abort immediately.
REQ-026 After reset release, no conversion SHALL start until a new done rising edge.

Structure
REQ-027 Shared package matx_display_pkg SHALL hold:
- the FSM state enum;
- MAT_DIM = 4, ELEM_W = 32, BIN_W = 12, BCD_DIGITS = 3;
- the default SAT_MAX.
REQ-028 The conversion datapath SHALL be one sub-module, bin12_to_bcd_seq, with a start/done handshake. The scan FSM, snapshot and tick counter stay in result_scan_bcd.

Verification
REQ-029 Reset, then done rises with element [3][0] = 123 (TICK_CYCLES = 16) -> after 14 cycles: row_idx = 3, col_idx = 0, digits 1/2/3, bcd_valid = 1.
REQ-030 Elements 999, 1000 and 0xFFFFFFFF -> each shows 9/9/9; element 0 -> 0/0/0; element 4096 -> 9/9/9.
REQ-031 Scan all 16 elements with TICK_CYCLES = 16 -> coordinates in order (3,0),(3,1),(3,2),(3,3),(2,0)...(0,3), then wrap to (3,0); each update exactly 16 cycles apart.
REQ-032 Second done rising edge during SHIFT of idx 5, with changed result -> conversion aborts, idx = 0, and the new [3][0] value appears 14 cycles after the edge.
REQ-033 done held high for 100 cycles -> exactly one capture; changing result while done stays high -> no effect on the outputs.
REQ-034 reset_n asserted during SHIFT -> all outputs 0 in the same cycle; after release, outputs stay 0 with no done edge.

Source files
------------

// File: rtl/matx_display_pkg.sv
// rtl/matx_display_pkg.sv - shared types and constants for the matrix result display
package matx_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD
    } scan_state_t;

    localparam int MAT_DIM         = 4;
    localparam int ELEM_W          = 32;
    localparam int ROW_W           = MAT_DIM * ELEM_W;
    localparam int BIN_W           = 12;
    localparam int BCD_DIGITS      = 3;
    localparam int BCD_W           = 4 * BCD_DIGITS;
    localparam int SAT_MAX_DEFAULT = 999;

    // Full-width compare so large values clamp instead of wrapping in the low bits.
    function automatic logic [BIN_W-1:0] saturate(input logic [ELEM_W-1:0] value,
                                                   input int limit);
        logic [ELEM_W-1:0] lim;
        lim = ELEM_W'(limit);
        return (value > lim) ? lim[BIN_W-1:0] : value[BIN_W-1:0];
    endfunction

endpackage

// File: rtl/bin12_to_bcd_seq.sv
// rtl/bin12_to_bcd_seq.sv - sequential 12-bit binary to 3-digit BCD converter (double-dabble)
module bin12_to_bcd_seq
    import matx_display_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic [BCD_W-1:0] acc_nx;
    logic [3:0]       shift_cnt;
    logic             active;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign acc_nx = {acc_adj[BCD_W-2:0], bin_sr[BIN_W-1]};

    // done and bcd reflect the shift being taken on this edge, so the caller
    // can capture the final digits on the same edge as the last shift.
    assign done = active && (shift_cnt == 4'(BIN_W - 1));
    assign bcd  = acc_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr    <= '0;
            acc       <= '0;
            shift_cnt <= '0;
            active    <= 1'b0;
        end else if (start) begin
            bin_sr    <= bin;
            acc       <= '0;
            shift_cnt <= '0;
            active    <= 1'b1;
        end else if (active) begin
            bin_sr    <= bin_sr << 1;
            acc       <= acc_nx;
            shift_cnt <= shift_cnt + 4'd1;
            if (shift_cnt == 4'(BIN_W - 1)) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/result_scan_bcd.sv
// rtl/result_scan_bcd.sv - snapshots a result matrix and scans its elements as BCD digits
module result_scan_bcd
    import matx_display_pkg::*;
#(
    parameter int TICK_CYCLES = 25_000_000,
    parameter int SAT_MAX     = SAT_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             done,
    input  logic [ROW_W-1:0] result [MAT_DIM],
    output logic [3:0]       bcd_hundreds,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic [1:0]       row_idx,
    output logic [1:0]       col_idx,
    output logic             bcd_valid,
    output logic             busy
);

    localparam int              CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    scan_state_t      state;
    scan_state_t      state_nx;

    logic [ROW_W-1:0] snap [MAT_DIM];
    logic             done_q;
    logic             running;
    logic             pending;
    logic [CNT_W-1:0] tick_cnt;
    logic [3:0]       idx;

    logic             capture;
    logic             tick;
    logic             advance;
    logic [1:0]       elem_row;
    logic [ELEM_W-1:0] elem;
    logic [BIN_W-1:0] sat_val;
    logic             conv_start;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    assign capture    = done & ~done_q;
    assign tick       = running && (tick_cnt == TICK_LAST);
    assign advance    = (state == ST_HOLD) && (tick || pending);
    assign busy       = (state == ST_LOAD) || (state == ST_SHIFT);
    assign conv_start = (state == ST_LOAD);

    // Element 0 is the bottom-left of the matrix; rows are walked upward.
    assign elem_row = 2'd3 - idx[3:2];

    always_comb begin
        elem    = snap[elem_row][{idx[1:0], 5'b0} +: ELEM_W];
        sat_val = saturate(elem, SAT_MAX);
    end

    bin12_to_bcd_seq u_conv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (sat_val),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = ST_IDLE;
            ST_LOAD:  state_nx = ST_SHIFT;
            ST_SHIFT: if (conv_done) state_nx = ST_HOLD;
            ST_HOLD:  if (advance) state_nx = ST_LOAD;
            default:  state_nx = ST_IDLE;
        endcase
        if (capture) begin
            state_nx = ST_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < MAT_DIM; r++) begin
                snap[r] <= '0;
            end
            done_q   <= 1'b0;
            running  <= 1'b0;
            pending  <= 1'b0;
            tick_cnt <= '0;
            idx      <= '0;
        end else begin
            done_q <= done;
            if (capture) begin
                for (int r = 0; r < MAT_DIM; r++) begin
                    snap[r] <= result[r];
                end
                running  <= 1'b1;
                pending  <= 1'b0;
                tick_cnt <= '0;
                idx      <= '0;
            end else begin
                if (running) begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                end
                if (advance) begin
                    idx     <= idx + 4'd1;
                    pending <= 1'b0;
                end else if (tick && (state != ST_HOLD)) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    // Visible outputs only change on HOLD entry; a capture on that edge aborts the update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
            row_idx      <= '0;
            col_idx      <= '0;
            bcd_valid    <= 1'b0;
        end else if ((state == ST_SHIFT) && conv_done && !capture) begin
            bcd_hundreds <= conv_bcd[11:8];
            bcd_tens     <= conv_bcd[7:4];
            bcd_ones     <= conv_bcd[3:0];
            row_idx      <= elem_row;
            col_idx      <= idx[1:0];
            bcd_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_scan_bcd.sv
// tb/tb_result_scan_bcd.sv - self-checking bench for result_scan_bcd
module tb_result_scan_bcd;

    localparam int TICK = 16;
    localparam int SAT  = 999;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         done;
    logic [127:0] result [4];
    logic [3:0]   bcd_hundreds;
    logic [3:0]   bcd_tens;
    logic [3:0]   bcd_ones;
    logic [1:0]   row_idx;
    logic [1:0]   col_idx;
    logic         bcd_valid;
    logic         busy;

    logic [127:0] exp_snap [4];
    logic [17:0]  last_vec;
    int           checks = 0;
    int           errors = 0;

    result_scan_bcd #(
        .TICK_CYCLES (TICK),
        .SAT_MAX     (SAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .done         (done),
        .result       (result),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .row_idx      (row_idx),
        .col_idx      (col_idx),
        .bcd_valid    (bcd_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] dut_vec();
        return {row_idx, col_idx, bcd_hundreds, bcd_tens, bcd_ones, bcd_valid, busy};
    endfunction

    // Expected display for scan step k, from decimal arithmetic on the snapshot value.
    function automatic logic [17:0] model_vec(input int k);
        int          i;
        int          s;
        logic [31:0] v;
        i = k % 16;
        v = exp_snap[3 - i / 4][32 * (i % 4) +: 32];
        s = (v > 32'(SAT)) ? SAT : int'(v);
        return {2'(3 - i / 4), 2'(i % 4), 4'(s / 100), 4'((s / 10) % 10), 4'(s % 10), 1'b1, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_result();
        logic [31:0] v;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case ($urandom_range(0, 3))
                    0:       v = $urandom;
                    1:       v = $urandom_range(990, 1010);
                    default: v = $urandom_range(0, 999);
                endcase
                result[r][32 * c +: 32] = v;
            end
        end
    endtask

    // Raises done at the current negedge and follows the scan for last_p clock edges.
    task automatic run_scan(input int done_cycles, input int change_at, input int last_p);
        exp_snap = result;
        done     = 1'b1;
        for (int p = 1; p <= last_p; p++) begin
            @(posedge clk);
            @(negedge clk);
            if (p == done_cycles) done = 1'b0;
            if (p == change_at) randomize_result();
            if (p >= 13 && (p - 13) % 16 == 0)
                chk($sformatf("held_p%0d", p), 32'(dut_vec()), 32'({last_vec[17:1], 1'b1}));
            if (p >= 14 && (p - 14) % 16 == 0) begin
                last_vec = model_vec((p - 14) / 16);
                chk($sformatf("update_p%0d", p), 32'(dut_vec()), 32'(last_vec));
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        done     = 1'b0;
        last_vec = '0;
        randomize_result();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(dut_vec()), 32'd0);

        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("no_start_after_reset", 32'(dut_vec()), 32'd0);

        randomize_result();
        result[3][31:0] = 32'd123;
        run_scan(1, 0, 30);

        randomize_result();
        result[3][31:0]   = 32'd999;
        result[3][63:32]  = 32'd1000;
        result[3][95:64]  = 32'hFFFF_FFFF;
        result[3][127:96] = 32'd0;
        result[2][31:0]   = 32'd4096;
        run_scan(100, 50, 14 + 16 * 16);

        randomize_result();
        run_scan(3, 0, 86);
        chk("busy_in_shift_idx5", 32'(busy), 32'd1);
        randomize_result();
        result[3][31:0] = (exp_snap[3][31:0] == 32'd321) ? 32'd654 : 32'd321;
        run_scan(3, 0, 30);

        randomize_result();
        run_scan(2, 0, 20);
        chk("busy_before_reset", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_midshift", 32'(dut_vec()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("idle_after_midshift_reset", 32'(dut_vec()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
